serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/sub_pkg.sv | 19 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 158 +++++++++++++++
 tb/tb_serial_subtractor.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state type,
// default operand width and the signed-overflow helper.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 16;

    // Two's-complement overflow of a subtraction, computed from the sign bits
    // of the minuend, subtrahend and difference.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) & (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: difference and borrow-out of x - y - bin.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B modulo 2^WIDTH one bit per clock,
// LSB first, with a registered borrow-out and a one-cycle Done pulse.
// Optional feature: define SUB_OVF_FLAG_EN to add the signed-overflow output OV.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Diff,
    output logic             BO,
`ifdef SUB_OVF_FLAG_EN
    output logic             OV,
`endif
    output logic             Busy,
    output logic             Done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bin;
    logic             r_bo;
    logic             r_busy;
    logic             r_done;
    logic             w_d;
    logic             w_bout;

`ifdef SUB_OVF_FLAG_EN
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ov;
`endif

    full_subtractor u_fs (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    // State register; Reset wins over any pending Start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_last = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_next = RUN;
                    w_load = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            RUN: begin
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_next = DONE;
                    w_last = 1'b1;
                end else begin
                    w_next = RUN;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand capture, per-bit shifting and result commit on the final bit.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_a    <= {WIDTH{1'b0}};
            r_b    <= {WIDTH{1'b0}};
            r_res  <= {WIDTH{1'b0}};
            r_diff <= {WIDTH{1'b0}};
            r_cnt  <= {CNT_W{1'b0}};
            r_bin  <= 1'b0;
            r_bo   <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ov    <= 1'b0;
`endif
        end else if (w_load) begin
            r_a   <= A;
            r_b   <= B;
            r_res <= {WIDTH{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
            r_bin <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
`endif
        end else if (r_state == RUN) begin
            r_a   <= {1'b0, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_cnt <= r_cnt + CNT_W'(1);
            r_bin <= w_bout;
            if (w_last) begin
                // The final difference bit is still combinational here, so it
                // is merged in directly rather than waiting for the shift.
                r_diff <= {w_d, r_res[WIDTH-1:1]};
                r_bo   <= w_bout;
`ifdef SUB_OVF_FLAG_EN
                r_ov   <= sub_ovf(r_a_msb, r_b_msb, w_d);
`endif
            end
        end
    end

    // Registered status flags: Busy tracks RUN, Done pulses once after DONE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next == RUN);
            r_done <= (r_state == DONE);
        end
    end

    assign Diff = r_diff;
    assign BO   = r_bo;
    assign Busy = r_busy;
    assign Done = r_done;
`ifdef SUB_OVF_FLAG_EN
    assign OV   = r_ov;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 16).
module tb_serial_subtractor;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] Diff;
    logic        BO;
    logic        Busy;
    logic        Done;
`ifdef SUB_OVF_FLAG_EN
    logic        OV;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    serial_subtractor #(.WIDTH(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Diff  (Diff),
        .BO    (BO),
`ifdef SUB_OVF_FLAG_EN
        .OV    (OV),
`endif
        .Busy  (Busy),
        .Done  (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Launch one operation from IDLE and check latency, result and single pulse.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ed, input logic ebo, input logic eov);
        int  cyc;
        bit  seen;
        A = a;
        B = b;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check_val({tag, "_busy"}, {31'd0, Busy}, 32'd1);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            tick();
            cyc = i;
            if (Done) seen = 1'b1;
        end
        check_val({tag, "_latency"}, seen ? cyc : 0, 32'd17);
        check_val({tag, "_diff"}, {16'd0, Diff}, {16'd0, ed});
        check_val({tag, "_bo"}, {31'd0, BO}, {31'd0, ebo});
`ifdef SUB_OVF_FLAG_EN
        check_val({tag, "_ov"}, {31'd0, OV}, {31'd0, eov});
`else
        if (eov === 1'bx) $display("note: unexpected X overflow expectation");
`endif
        tick();
        check_val({tag, "_done_one_cycle"}, {31'd0, Done}, 32'd0);
    endtask

    initial begin
        int  dones;
        int  gap;
        bit  seen;

        Reset = 1'b1;
        Start = 1'b0;
        A     = 16'h0000;
        B     = 16'h0000;
        tick();
        tick();
        check_val("rst_diff", {16'd0, Diff}, 32'd0);
        check_val("rst_bo",   {31'd0, BO},   32'd0);
        check_val("rst_busy", {31'd0, Busy}, 32'd0);
        check_val("rst_done", {31'd0, Done}, 32'd0);
        Reset = 1'b0;
        tick();

        // Basic results and boundary operands.
        run_op("5m3",      16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
        run_op("0m1",      16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
        run_op("8000m1",   16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
        run_op("eq",       16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0);
        run_op("7fffmffff",16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);

        // Start and operand changes during RUN are ignored; Diff holds meanwhile.
        A = 16'h0010;
        B = 16'h0001;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (5) tick();
        check_val("hold_in_run", {16'd0, Diff}, 32'h8000);
        A = 16'hAAAA;
        B = 16'h5555;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Done) begin
                dones++;
                check_val("ignore_diff", {16'd0, Diff}, 32'h000F);
                check_val("ignore_bo",   {31'd0, BO},   32'd0);
            end
        end
        check_val("ignore_done_count", dones, 32'd1);

        // Reset in the middle of RUN aborts without a Done pulse.
        A = 16'h0009;
        B = 16'h0004;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (8) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_val("abort_busy", {31'd0, Busy}, 32'd0);
        check_val("abort_diff", {16'd0, Diff}, 32'd0);
        check_val("abort_bo",   {31'd0, BO},   32'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (Done) dones++;
            tick();
        end
        check_val("abort_no_done", dones, 32'd0);
        run_op("after_abort", 16'h0009, 16'h0004, 16'h0005, 1'b0, 1'b0);

        // Start held high: operations repeat every WIDTH+2 cycles.
        A = 16'hFFFF;
        B = 16'hFFFF;
        Start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (Done) seen = 1'b1;
        end
        check_val("b2b_first_done", {31'd0, seen}, 32'd1);
        check_val("b2b_diff", {16'd0, Diff}, 32'd0);
        check_val("b2b_bo",   {31'd0, BO},   32'd0);
        for (int k = 0; k < 2; k++) begin
            seen = 1'b0;
            gap  = 0;
            for (int i = 1; i <= 40 && !seen; i++) begin
                tick();
                gap = i;
                if (Done) seen = 1'b1;
            end
            check_val("b2b_period", seen ? gap : 0, 32'd18);
        end
        Start = 1'b0;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
